// File: rtl/regfile_2r1w.sv
// Parametrised register file with one write port and two registered read ports (P/Q).
// Supports optional write-to-read bypass, a hardwired-zero entry 0, and a self-timed clear sweep.
module regfile_2r1w #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             WR,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] LD_DATA,
  input  logic             RE,
  input  logic [AW-1:0]    RP,
  input  logic [AW-1:0]    RQ,
  input  logic             INIT,
  output logic [WIDTH-1:0] DATAP,
  output logic [WIDTH-1:0] DATAQ,
  output logic             BUSY
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [0:0]       r_state;
  logic [AW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_datap;
  logic [WIDTH-1:0] r_dataq;

  logic             w_wr_ok;
  logic             w_sweep;
  logic [WIDTH-1:0] w_rdp;
  logic [WIDTH-1:0] w_rdq;

  assign w_sweep = (r_state == ST_SWEEP);
  assign w_wr_ok = WR && !w_sweep && (int'(WA) < DEPTH) && !((ZERO_R0 != 0) && (WA == '0));

  // Read priority: out of range, then hardwired zero, then bypass, then stored value.
  function automatic logic [WIDTH-1:0] read_val(input logic [AW-1:0] a);
    if (int'(a) >= DEPTH)                        return '0;
    if ((ZERO_R0 != 0) && (a == '0))             return '0;
    if ((BYPASS != 0) && w_wr_ok && (WA == a))   return LD_DATA;
    return r_mem[a];
  endfunction

  always_comb begin
    w_rdp = read_val(RP);
    w_rdq = read_val(RQ);
  end

  // NOTE: the storage array sits under the async reset because CLR must zero every entry at once.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_datap <= '0;
      r_dataq <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_sweep && (int'(r_ptr) == i))
          r_mem[i] <= '0;
        else if (w_wr_ok && (int'(WA) == i))
          r_mem[i] <= LD_DATA;
      end

      if (RE) begin
        r_datap <= w_rdp;
        r_dataq <= w_rdq;
      end

      // INIT is only honoured in IDLE; a running sweep cannot be restarted.
      if (!w_sweep) begin
        if (INIT) begin
          r_state <= ST_SWEEP;
          r_ptr   <= '0;
        end
      end else begin
        r_ptr <= r_ptr + 1'b1;
        if (int'(r_ptr) == DEPTH - 1) r_state <= ST_IDLE;
      end
    end
  end

  assign DATAP = r_datap;
  assign DATAQ = r_dataq;
  assign BUSY  = r_state[0];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w: default, no-bypass and zero-r0/short-depth instances
// share one stimulus stream; each is checked only where its expected value is hand-derived.
module tb_regfile_2r1w;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       WR;
  logic [2:0] WA;
  logic [3:0] LD_DATA;
  logic       RE;
  logic [2:0] RP;
  logic [2:0] RQ;
  logic       INIT;

  logic [3:0] d_p, d_q, n_p, n_q, z_p, z_q;
  logic       d_busy, n_busy, z_busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  regfile_2r1w u_dut (
    .CLK(CLK), .CLR(CLR), .WR(WR), .WA(WA), .LD_DATA(LD_DATA), .RE(RE),
    .RP(RP), .RQ(RQ), .INIT(INIT), .DATAP(d_p), .DATAQ(d_q), .BUSY(d_busy)
  );

  regfile_2r1w #(.BYPASS(0)) u_nb (
    .CLK(CLK), .CLR(CLR), .WR(WR), .WA(WA), .LD_DATA(LD_DATA), .RE(RE),
    .RP(RP), .RQ(RQ), .INIT(INIT), .DATAP(n_p), .DATAQ(n_q), .BUSY(n_busy)
  );

  regfile_2r1w #(.DEPTH(6), .ZERO_R0(1)) u_z (
    .CLK(CLK), .CLR(CLR), .WR(WR), .WA(WA), .LD_DATA(LD_DATA), .RE(RE),
    .RP(RP), .RQ(RQ), .INIT(INIT), .DATAP(z_p), .DATAQ(z_q), .BUSY(z_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    WR = 1'b1; WA = a; LD_DATA = d; RE = 1'b0;
    tick();
    WR = 1'b0;
  endtask

  initial begin
    CLR = 1'b1; WR = 1'b0; WA = '0; LD_DATA = '0; RE = 1'b0;
    RP = '0; RQ = '0; INIT = 1'b0;
    tick(); tick();
    CLR = 1'b0;
    check("rst_datap", 32'(d_p), 32'h0);
    check("rst_busy", 32'(d_busy), 32'h0);

    // Basic write then registered read on both ports
    wr(3'd3, 4'hA);
    wr(3'd6, 4'h5);
    RE = 1'b1; RP = 3'd3; RQ = 3'd6;
    tick();
    check("rd_p3", 32'(d_p), 32'hA);
    check("rd_q6", 32'(d_q), 32'h5);
    check("z_oor_q6", 32'(z_q), 32'h0);
    RE = 1'b0; RP = 3'd0; RQ = 3'd1;
    tick();
    check("hold_p", 32'(d_p), 32'hA);
    check("hold_q", 32'(d_q), 32'h5);

    // Asynchronous clear mid-cycle
    #2 CLR = 1'b1;
    #1;
    check("aclr_p", 32'(d_p), 32'h0);
    check("aclr_q", 32'(d_q), 32'h0);
    check("aclr_busy", 32'(d_busy), 32'h0);
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 8; i++) begin
      RE = 1'b1; RP = 3'(i); RQ = 3'(7 - i);
      tick();
      check($sformatf("rst_rd_p%0d", i), 32'(d_p), 32'h0);
      check($sformatf("rst_rd_q%0d", 7 - i), 32'(d_q), 32'h0);
    end

    // Same-edge write and read of entry 2
    wr(3'd2, 4'h1);
    WR = 1'b1; WA = 3'd2; LD_DATA = 4'hC; RE = 1'b1; RP = 3'd2; RQ = 3'd2;
    tick();
    check("byp_p", 32'(d_p), 32'hC);
    check("byp_q", 32'(d_q), 32'hC);
    check("nobyp_p", 32'(n_p), 32'h1);
    check("nobyp_q", 32'(n_q), 32'h1);
    check("z_byp_p", 32'(z_p), 32'hC);
    WR = 1'b0;
    tick();
    check("nobyp_next_p", 32'(n_p), 32'hC);

    // Hardwired zero on entry 0 and out-of-range reads
    wr(3'd0, 4'hF);
    wr(3'd1, 4'hF);
    RE = 1'b1; RP = 3'd0; RQ = 3'd1;
    tick();
    check("z_r0", 32'(z_p), 32'h0);
    check("z_r1", 32'(z_q), 32'hF);
    check("d_r0", 32'(d_p), 32'hF);
    WR = 1'b1; WA = 3'd0; LD_DATA = 4'h7; RP = 3'd0;
    tick();
    WR = 1'b0;
    check("z_r0_byp", 32'(z_p), 32'h0);
    check("d_r0_byp", 32'(d_p), 32'h7);
    RP = 3'd7; RQ = 3'd6;
    tick();
    check("z_oor_p7", 32'(z_p), 32'h0);
    check("z_oor_q6b", 32'(z_q), 32'h0);

    // Clear sweep over a filled array, with writes attempted during it
    for (int i = 0; i < 8; i++) wr(3'(i), 4'(i + 1));
    RE = 1'b0; INIT = 1'b1;
    tick();
    INIT = 1'b0;
    check("sw_busy0", 32'(d_busy), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      WR = 1'b1; WA = 3'd7; LD_DATA = 4'h9;
      RE = 1'b1; RP = 3'd7; RQ = (k >= 2) ? 3'(k - 2) : 3'd0;
      INIT = (k == 4);
      tick();
      check($sformatf("sw_busy%0d", k), 32'(d_busy), 32'(k < 8));
      check($sformatf("z_sw_busy%0d", k), 32'(z_busy), 32'(k < 6));
      check($sformatf("sw_p7_%0d", k), 32'(d_p), 32'h8);
      check($sformatf("sw_q_%0d", k), 32'(d_q), (k == 1) ? 32'h1 : 32'h0);
    end
    WR = 1'b0; INIT = 1'b0;
    for (int i = 0; i < 8; i++) begin
      RE = 1'b1; RP = 3'(i); RQ = 3'(i);
      tick();
      check($sformatf("post_sw_p%0d", i), 32'(d_p), 32'h0);
    end
    check("post_sw_busy", 32'(d_busy), 32'h0);

    // Asynchronous clear in the middle of a sweep
    wr(3'd5, 4'hE);
    wr(3'd7, 4'hD);
    INIT = 1'b1;
    tick();
    INIT = 1'b0;
    repeat (4) tick();
    check("msw_busy_before", 32'(d_busy), 32'h1);
    #2 CLR = 1'b1;
    #1;
    check("msw_busy_clr", 32'(d_busy), 32'h0);
    tick();
    CLR = 1'b0;
    RE = 1'b1; RP = 3'd5; RQ = 3'd7;
    tick();
    check("msw_p5", 32'(d_p), 32'h0);
    check("msw_q7", 32'(d_q), 32'h0);
    check("msw_busy_after", 32'(d_busy), 32'h0);
    wr(3'd5, 4'h3);
    RE = 1'b1; RP = 3'd5;
    tick();
    check("msw_wr5", 32'(d_p), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
